// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state type and helpers for the six-digit display scanner.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Field currently under adjustment
    localparam logic [1:0] ADJ_NONE = 2'b00;
    localparam logic [1:0] ADJ_SEC  = 2'b01;
    localparam logic [1:0] ADJ_MIN  = 2'b10;
    localparam logic [1:0] ADJ_HOUR = 2'b11;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // True when the digit at this index belongs to the field being adjusted
    function automatic logic inAdjustField(input logic [2:0] index, input logic [1:0] adjust);
        logic hit;
        hit = 1'b0;
        case (adjust)
            ADJ_SEC:  hit = (index == 3'd0) || (index == 3'd1);
            ADJ_MIN:  hit = (index == 3'd2) || (index == 3'd3);
            ADJ_HOUR: hit = (index == 3'd4) || (index == 3'd5);
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Separator dots sit after the hour and minute pairs (hh.mm.ss)
    function automatic logic hasDot(input logic [2:0] index);
        return (index == 3'd2) || (index == 3'd4);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// BCD to 7-segment decoder; non-decimal codes show a dash.
module seg_scan_ctrl_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup, dp is added by the scanner
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed display scanner with per-frame shadowing and field blink.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int BLINK_HZ    = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_hour_h,
    input  logic [3:0] i_hour_l,
    input  logic [3:0] i_minut_h,
    input  logic [3:0] i_minut_l,
    input  logic [3:0] i_second_h,
    input  logic [3:0] i_second_l,
    input  logic [1:0] i_adjust_cnt,
    output logic [5:0] o_seg_sel,
    output logic [7:0] o_seg_data,
    output logic       o_frame_done
);

    localparam int DIV     = CLK_FREQ_HZ / SCAN_HZ;
    localparam int HALF    = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int DIV_W   = $clog2(DIV);
    localparam int BLINK_W = $clog2(HALF + 1);

    logic [DIV_W-1:0]               r_preCnt;
    logic [BLINK_W-1:0]             r_blinkCnt;
    logic                           r_phase;
    scan_state_e                    r_state;
    logic [2:0]                     r_index;
    logic [NUM_DIGITS-1:0][3:0]     r_digits;
    logic [1:0]                     r_adjust;
    logic [5:0]                     r_segSel;
    logic [7:0]                     r_segData;
    logic                           r_frameDone;

    logic                           w_tick;
    logic                           w_capture;
    logic                           w_adjChange;
    scan_state_e                    w_nextState;
    logic [2:0]                     w_nextIndex;
    logic [NUM_DIGITS-1:0][3:0]     w_inDigits;
    logic [NUM_DIGITS-1:0][3:0]     w_nextDigits;
    logic [1:0]                     w_nextAdjust;
    logic [BLINK_W-1:0]             w_nextBlinkCnt;
    logic                           w_nextPhase;
    logic [6:0]                     w_segCode;
    logic [5:0]                     w_nextSel;
    logic [7:0]                     w_nextData;
    logic                           w_nextFrameDone;

    assign w_tick      = (r_preCnt == DIV_W'(DIV - 1));
    assign w_inDigits  = {i_hour_h, i_hour_l, i_minut_h, i_minut_l, i_second_h, i_second_l};

    // The BLANK cycle in front of digit 0 (including the reset state) latches a whole frame
    assign w_capture    = (r_state == ST_BLANK) && (r_index == 3'd0);
    assign w_adjChange  = w_capture && (i_adjust_cnt != r_adjust);
    assign w_nextDigits = w_capture ? w_inDigits : r_digits;
    assign w_nextAdjust = w_capture ? i_adjust_cnt : r_adjust;

    // Free-running prescaler producing the digit-advance tick
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_preCnt <= '0;
        end else if (w_tick) begin
            r_preCnt <= '0;
        end else begin
            r_preCnt <= r_preCnt + DIV_W'(1);
        end
    end

    // Blink phase; a new adjust field restarts in its visible half
    always_comb begin
        w_nextBlinkCnt = r_blinkCnt + BLINK_W'(1);
        w_nextPhase    = r_phase;
        if (w_adjChange) begin
            w_nextBlinkCnt = '0;
            w_nextPhase    = 1'b0;
        end else if (r_blinkCnt == BLINK_W'(HALF - 1)) begin
            w_nextBlinkCnt = '0;
            w_nextPhase    = ~r_phase;
        end
    end

    // Scan FSM next state: one BLANK cycle between digits, index moves on the tick
    always_comb begin
        w_nextState = r_state;
        w_nextIndex = r_index;
        case (r_state)
            ST_BLANK: w_nextState = ST_DRIVE;
            ST_DRIVE: begin
                if (w_tick) begin
                    w_nextState = ST_BLANK;
                    w_nextIndex = (r_index == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_index + 3'd1;
                end
            end
            default:  w_nextState = ST_BLANK;
        endcase
    end

    seg_scan_ctrl_decode u_decode (
        .i_bcd (w_nextDigits[w_nextIndex]),
        .o_seg (w_segCode)
    );

    // Outputs are computed from next-state values so select and data land together
    always_comb begin
        w_nextSel       = 6'h3F;
        w_nextData      = 8'hFF;
        w_nextFrameDone = 1'b0;
        if (w_nextState == ST_DRIVE) begin
            w_nextSel = ~(6'b000001 << w_nextIndex);
            if (!(w_nextPhase && inAdjustField(w_nextIndex, w_nextAdjust))) begin
                w_nextData = {~hasDot(w_nextIndex), w_segCode};
            end
        end else if (r_state == ST_DRIVE) begin
            w_nextFrameDone = (w_nextIndex == 3'd0);
        end
    end

    // State, shadow, blink and output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_BLANK;
            r_index     <= 3'd0;
            r_digits    <= '0;
            r_adjust    <= ADJ_NONE;
            r_blinkCnt  <= '0;
            r_phase     <= 1'b0;
            r_segSel    <= 6'h3F;
            r_segData   <= 8'hFF;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_index     <= w_nextIndex;
            r_digits    <= w_nextDigits;
            r_adjust    <= w_nextAdjust;
            r_blinkCnt  <= w_nextBlinkCnt;
            r_phase     <= w_nextPhase;
            r_segSel    <= w_nextSel;
            r_segData   <= w_nextData;
            r_frameDone <= w_nextFrameDone;
        end
    end

    assign o_seg_sel    = r_segSel;
    assign o_seg_data   = r_segData;
    assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl at DIV=10, HALF=20.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic [1:0] adj;
    logic [5:0] o_seg_sel;
    logic [7:0] o_seg_data;
    logic       o_frame_done;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] data;
        logic       fd;
    } exp_t;

    exp_t q[$];

    // Reference model state: cycle number since reset release and per-frame latches
    int         mdl_c;
    int         mdl_org;
    logic [3:0] mdl_dig[6];
    logic [1:0] mdl_adj;
    logic       mdl_phase;
    logic [7:0] DEC[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_scan_ctrl #(
        .CLK_FREQ_HZ (1000),
        .SCAN_HZ     (100),
        .BLINK_HZ    (25)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_hour_h     (hh),
        .i_hour_l     (hl),
        .i_minut_h    (mh),
        .i_minut_l    (ml),
        .i_second_h   (sh),
        .i_second_l   (sl),
        .i_adjust_cnt (adj),
        .o_seg_sel    (o_seg_sel),
        .o_seg_data   (o_seg_data),
        .o_frame_done (o_frame_done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic model_reset();
        mdl_c   = -1;
        mdl_org = -1;
        mdl_adj = 2'b00;
        for (int i = 0; i < 6; i++) mdl_dig[i] = 4'd0;
        q.delete();
    endtask

    // Predict outputs for the cycle following the next rising edge
    task automatic predict();
        exp_t       e;
        int         idx;
        int         pos;
        logic [7:0] code;
        logic       fieldHit;
        mdl_c++;
        if (mdl_c % 60 == 0) begin
            if (adj != mdl_adj) mdl_org = mdl_c;
            mdl_adj = adj;
            mdl_dig = '{sl, sh, ml, mh, hl, hh};
        end
        pos       = mdl_c % 10;
        idx       = (mdl_c / 10) % 6;
        mdl_phase = (((mdl_c - mdl_org) / 20) % 2) == 1;
        e.fd      = 1'b0;
        if (pos == 9) begin
            e.sel  = 6'h3F;
            e.data = 8'hFF;
            e.fd   = (idx == 5);
        end else begin
            e.sel = 6'h3F & ~(6'h01 << idx);
            code  = (mdl_dig[idx] <= 4'd9) ? DEC[mdl_dig[idx]] : 8'hBF;
            if (idx == 2 || idx == 4) code[7] = 1'b0;
            fieldHit = (mdl_adj == 2'b01 && idx < 2) ||
                       (mdl_adj == 2'b10 && (idx == 2 || idx == 3)) ||
                       (mdl_adj == 2'b11 && idx >= 4);
            e.data = (mdl_phase && fieldHit) ? 8'hFF : code;
        end
        q.push_back(e);
    endtask

    // Called at a falling edge with inputs settled; returns at the next falling edge
    task automatic step();
        predict();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {hh, hl, mh, ml, sh, sl} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        adj = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg_sel !== 6'h3F) $display("[TB] FAIL reset_sel got %h want 3f", o_seg_sel);
        else passed++;
        checks++;
        if (o_seg_data !== 8'hFF) $display("[TB] FAIL reset_data got %h want ff", o_seg_data);
        else passed++;
        checks++;
        if (o_frame_done !== 1'b0) $display("[TB] FAIL reset_fd got %b want 0", o_frame_done);
        else passed++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        exp_t       e;
        logic [5:0] selTab[6]  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        logic [7:0] dataTab[6] = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};
        for (int n = 0; n < 60; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL scan c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (mdl_c % 10 == 4) begin
                checks++;
                if ({o_seg_sel, o_seg_data} !== {selTab[mdl_c / 10], dataTab[mdl_c / 10]})
                    $display("[TB] FAIL scan_table digit %0d got %h/%h want %h/%h", mdl_c / 10,
                             o_seg_sel, o_seg_data, selTab[mdl_c / 10], dataTab[mdl_c / 10]);
                else passed++;
            end
        end
    endtask

    task automatic test_frame_done();
        exp_t e;
        int   lastPulse = -1;
        int   pulses = 0;
        for (int n = 0; n < 130; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL frame c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (o_frame_done === 1'b1) begin
                if (lastPulse >= 0) begin
                    checks++;
                    if (mdl_c - lastPulse != 60)
                        $display("[TB] FAIL frame_period got %0d want 60", mdl_c - lastPulse);
                    else passed++;
                end
                lastPulse = mdl_c;
                pulses++;
            end
        end
        checks++;
        if (pulses != 2) $display("[TB] FAIL frame_pulses got %0d want 2", pulses);
        else passed++;
    endtask

    task automatic test_mid_frame();
        exp_t e;
        int   startFrame;
        for (int n = 0; n < 60 && (mdl_c % 60) != 30; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL midsync c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
        end
        startFrame = mdl_c / 60;
        sl = 4'd7;
        hh = 4'd0;
        for (int n = 0; n < 150 && (mdl_c / 60) < startFrame + 2; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL mid c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (mdl_c / 60 == startFrame && mdl_c % 60 == 54) begin
                checks++;
                if (o_seg_data !== 8'hF9) $display("[TB] FAIL mid_old_hour got %h want f9", o_seg_data);
                else passed++;
            end
            if (mdl_c / 60 == startFrame + 1 && mdl_c % 60 == 4) begin
                checks++;
                if (o_seg_data !== 8'hF8) $display("[TB] FAIL mid_new_sec got %h want f8", o_seg_data);
                else passed++;
            end
            if (mdl_c / 60 == startFrame + 1 && mdl_c % 60 == 54) begin
                checks++;
                if (o_seg_data !== 8'hC0) $display("[TB] FAIL mid_new_hour got %h want c0", o_seg_data);
                else passed++;
            end
        end
        hh = 4'd1;
    endtask

    task automatic test_blink();
        exp_t e;
        int   fieldBlank = 0;
        int   otherBlank = 0;
        adj = 2'b10;
        for (int n = 0; n < 200; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL blink c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (o_seg_data === 8'hFF && (o_seg_sel === 6'h3B || o_seg_sel === 6'h37)) fieldBlank++;
            if (o_seg_data === 8'hFF && o_seg_sel !== 6'h3F && o_seg_sel !== 6'h3B && o_seg_sel !== 6'h37)
                otherBlank++;
        end
        checks++;
        if (fieldBlank == 0) $display("[TB] FAIL blink_field got %0d blank cycles want >0", fieldBlank);
        else passed++;
        checks++;
        if (otherBlank != 0) $display("[TB] FAIL blink_other got %0d blank cycles want 0", otherBlank);
        else passed++;
    endtask

    task automatic test_adjust_switch();
        exp_t e;
        int   captureC;
        int   steady23 = 0;
        int   blank45 = 0;
        int   firstVis45 = 0;
        for (int n = 0; n < 60 && !mdl_phase; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL swsync c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
        end
        checks++;
        if (mdl_phase !== 1'b1) $display("[TB] FAIL switch_phase got %b want 1", mdl_phase);
        else passed++;
        adj = 2'b11;
        captureC = (mdl_c / 60 + 1) * 60;
        for (int n = 0; n < 200 && mdl_c < captureC + 120; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL switch c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (mdl_c >= captureC && o_seg_data === 8'hFF && (o_seg_sel === 6'h3B || o_seg_sel === 6'h37))
                steady23++;
            if (mdl_c >= captureC && o_seg_data === 8'hFF && (o_seg_sel === 6'h2F || o_seg_sel === 6'h1F))
                blank45++;
            if (mdl_c >= captureC && mdl_c < captureC + 60 && o_seg_data !== 8'hFF &&
                (o_seg_sel === 6'h2F || o_seg_sel === 6'h1F))
                firstVis45++;
        end
        checks++;
        if (steady23 != 0) $display("[TB] FAIL switch_steady23 got %0d blank cycles want 0", steady23);
        else passed++;
        checks++;
        if (blank45 == 0) $display("[TB] FAIL switch_blink45 got %0d blank cycles want >0", blank45);
        else passed++;
        checks++;
        if (firstVis45 != 18) $display("[TB] FAIL switch_first_frame45 got %0d visible want 18", firstVis45);
        else passed++;
    endtask

    task automatic test_dash_and_reset();
        exp_t e;
        int   startFrame;
        adj = 2'b00;
        sl  = 4'hC;
        startFrame = mdl_c / 60;
        for (int n = 0; n < 130 && !(mdl_c / 60 > startFrame && mdl_c % 60 == 4); n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL dash c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
        end
        checks++;
        if ({o_seg_sel, o_seg_data} !== {6'h3E, 8'hBF})
            $display("[TB] FAIL dash_code got %h/%h want 3e/bf", o_seg_sel, o_seg_data);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_seg_sel, o_seg_data, o_frame_done} !== {6'h3F, 8'hFF, 1'b0})
            $display("[TB] FAIL async_reset got %h/%h/%b want 3f/ff/0", o_seg_sel, o_seg_data, o_frame_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        sl = 4'd6;
        model_reset();
        for (int n = 0; n < 60; n++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({o_seg_sel, o_seg_data, o_frame_done} !== {e.sel, e.data, e.fd})
                $display("[TB] FAIL restart c=%0d got %h/%h/%b want %h/%h/%b", mdl_c,
                         o_seg_sel, o_seg_data, o_frame_done, e.sel, e.data, e.fd);
            else passed++;
            if (n == 0) begin
                checks++;
                if (o_seg_sel !== 6'h3E) $display("[TB] FAIL restart_first got %h want 3e", o_seg_sel);
                else passed++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_scan();
        test_frame_done();
        test_mid_frame();
        test_blink();
        test_adjust_switch();
        test_dash_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
